sr_flop_bank: RTL and testbench
===============================

# sr_flop_bank

Parametrised, clocked bank of WIDTH independent set/reset storage channels, the synchronous successor to the team's single-bit level-sensitive SR latch. Each channel resolves Set/Reset requests under a selectable priority mode, optionally enforces a post-change lockout window, and reports one-cycle change pulses. It sits between raw control or status request lines and downstream logic that needs glitch-free, registered flag state.

## Interface
Parameters:
- WIDTH, 8, number of independent channels (1..32)
- MODE, 0, conflict resolution when Set and Reset are both high: 0 set-dominant, 1 reset-dominant, 2 toggle, 3 hold
- HOLD_CYCLES, 0, lockout length in cycles after a Q change; 0 disables lockout
- INIT, {WIDTH{1'b0}}, per-channel Q value loaded at reset

Ports:
- Clk  input  1  sole clock, rising edge
- ResetN  input  1  synchronous, active-low reset
- Enable  input  1  global request-acceptance enable
- Set  input  WIDTH  per-channel set request
- Reset  input  WIDTH  per-channel clear request
- Q  output  WIDTH  registered channel state
- NotQ  output  WIDTH  bitwise inverse of Q
- Changed  output  WIDTH  one-cycle pulse, high in the cycle Q shows a new value
- Busy  output  WIDTH  channel in lockout; requests ignored

## Operation
- Reset (ResetN low at a Clk edge): Q=INIT, NotQ=~INIT, Changed=0, Busy=0, lockout counters=0, edge-detect history=0. Reset mid-lockout aborts lockout.
- Per channel, request decode when Enable=1 and Busy=0: Set only -> next Q=1; Reset only -> next Q=0; both -> per MODE (0: 1, 1: 0, 2: ~Q, 3: Q); neither -> hold.
- Enable=0: Q holds, all requests dropped; lockout counters keep decrementing.
- Changed[i]=1 exactly when Q[i] differs from its previous-cycle value; a request that does not alter Q (Set while Q=1) gives no pulse and no lockout.
- Lockout (HOLD_CYCLES>0): a Q change loads counter with HOLD_CYCLES; Busy[i]=(counter!=0); counter decrements by 1 each cycle to 0. Requests during Busy are discarded, never queued. Counter width $clog2(HOLD_CYCLES+1).
- HOLD_CYCLES=0: no counters generated, Busy tied 0.
- NotQ is combinational ~Q; all other outputs registered.
- Channels fully independent; no cross-channel priority.

## Timing
- Latency: request sampled at edge N -> Q and Changed updated after edge N (visible cycle N+1); Changed deasserts after edge N+1 unless another change occurs.
- Lockout: change at edge N -> Busy high cycles N+1..N+HOLD_CYCLES; first request accepted at edge N+HOLD_CYCLES+1... precisely, a request sampled at an edge where Busy=0 is accepted.
- MODE 2 with Set=Reset=1 held and HOLD_CYCLES=0: Q toggles every cycle, Changed stays high.
- Reset has priority over Enable and all requests in the same cycle.

## Configuration
- SR_FLOP_BANK_EDGE_EN defined: Set/Reset are edge-triggered; each bit registered into history every cycle (including when Enable=0 or Busy=1), and only rising edges (input=1, history=0) count as requests. Held-high inputs act once. History resets to 0, so an input high at reset release counts as an edge in the first cycle. No extra latency.
- Undefined: level-sensitive; any high Set/Reset at an accepting edge is a request. No history registers.

## Test plan
- WIDTH=4, INIT=4'b0101, hold ResetN low 2 cycles -> Q=0101, NotQ=1010, Changed=0, Busy=0.
- MODE=0/1/3, Set[0]=Reset[0]=1 one cycle from Q=0 -> Q[0]=1 / 0 / 0; Changed[0] pulses only for MODE 0.
- MODE=2, HOLD_CYCLES=3, Set=Reset=1 held 8 cycles from Q=0 -> Q toggles at edges 1 and 5 only; Busy high 3 cycles after each toggle.
- Enable=0 with Set=1111 for 3 cycles -> Q unchanged, Changed=0; Enable=1 -> Q=1111 next cycle, Changed=1111 one cycle.
- ResetN low while Busy=1 (HOLD_CYCLES=5) -> next cycle Busy=0, Q=INIT; Set accepted on first edge after release.
- With SR_FLOP_BANK_EDGE_EN, MODE=2, Set[1]=Reset[1]=1 held 5 cycles -> Q[1] toggles once; without macro -> toggles every cycle.

Source files
------------

// File: rtl/sr_flop_bank.sv
// sr_flop_bank: WIDTH independent clocked set/reset flags, MODE conflict resolution, optional post-change lockout.
// Latency: request at edge N shows on Q/Changed in cycle N+1; requests during Busy or Enable=0 are dropped, never queued.
// Define SR_FLOP_BANK_EDGE_EN for rising-edge request detection; default build is level-sensitive.
module sr_flop_bank #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      MODE        = 0,
   parameter int unsigned      HOLD_CYCLES = 0,
   parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}}
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic             Enable,
   input  logic [WIDTH-1:0] Set,
   input  logic [WIDTH-1:0] Reset,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] NotQ,
   output logic [WIDTH-1:0] Changed,
   output logic [WIDTH-1:0] Busy
);

   logic [WIDTH-1:0] set_req;
   logic [WIDTH-1:0] reset_req;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] changed;
   logic [WIDTH-1:0] busy;

`ifdef SR_FLOP_BANK_EDGE_EN
   logic [WIDTH-1:0] set_hist;
   logic [WIDTH-1:0] reset_hist;

   // History tracks the raw inputs every cycle, even while requests are being dropped.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         set_hist   <= '0;
         reset_hist <= '0;
      end else begin
         set_hist   <= Set;
         reset_hist <= Reset;
      end
   end

   assign set_req   = Set & ~set_hist;
   assign reset_req = Reset & ~reset_hist;
`else
   assign set_req   = Set;
   assign reset_req = Reset;
`endif

   assign accept = {WIDTH{Enable}} & ~busy;

   always_comb begin
      q_nxt = q;
      for (int i = 0; i < WIDTH; i++) begin
         if (accept[i]) begin
            case ({set_req[i], reset_req[i]})
               2'b10:   q_nxt[i] = 1'b1;
               2'b01:   q_nxt[i] = 1'b0;
               2'b11: begin
                  case (MODE)
                     0:       q_nxt[i] = 1'b1;
                     1:       q_nxt[i] = 1'b0;
                     2:       q_nxt[i] = ~q[i];
                     default: q_nxt[i] = q[i];
                  endcase
               end
               default: q_nxt[i] = q[i];
            endcase
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         q       <= INIT;
         changed <= '0;
      end else begin
         q       <= q_nxt;
         changed <= q_nxt ^ q;
      end
   end

   generate
      if (HOLD_CYCLES > 0) begin : g_lockout
         localparam int unsigned      CNT_W     = $clog2(HOLD_CYCLES + 1);
         localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

         for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [CNT_W-1:0] cnt;

            // Only an actual Q change starts a lockout window.
            always_ff @(posedge Clk) begin
               if (!ResetN) begin
                  cnt <= '0;
               end else if (q_nxt[i] != q[i]) begin
                  cnt <= HOLD_LOAD;
               end else if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            assign busy[i] = (cnt != '0);
         end
      end else begin : g_no_lockout
         assign busy = '0;
      end
   endgenerate

   assign Q       = q;
   assign NotQ    = ~q;
   assign Changed = changed;
   assign Busy    = busy;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank: six 4-channel instances covering each MODE and lockout length.
// Expectations follow the build's request style (level or edge) selected by SR_FLOP_BANK_EDGE_EN.
module tb_sr_flop_bank;

`ifdef SR_FLOP_BANK_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       ResetN;
   logic       Enable;
   logic [3:0] Set;
   logic [3:0] Reset;

   logic [3:0] q  [6];
   logic [3:0] nq [6];
   logic [3:0] ch [6];
   logic [3:0] bz [6];

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   // 0: set-dominant, INIT 0101      1: reset-dominant      2: toggle, hold 3
   // 3: hold mode                    4: set-dominant, hold 5, INIT 0101   5: toggle, no hold
   sr_flop_bank #(.WIDTH(4), .MODE(0), .HOLD_CYCLES(0), .INIT(4'b0101)) u0 (
      .Clk(Clk), .ResetN(ResetN), .Enable(Enable), .Set(Set), .Reset(Reset),
      .Q(q[0]), .NotQ(nq[0]), .Changed(ch[0]), .Busy(bz[0]));
   sr_flop_bank #(.WIDTH(4), .MODE(1), .HOLD_CYCLES(0), .INIT(4'b0000)) u1 (
      .Clk(Clk), .ResetN(ResetN), .Enable(Enable), .Set(Set), .Reset(Reset),
      .Q(q[1]), .NotQ(nq[1]), .Changed(ch[1]), .Busy(bz[1]));
   sr_flop_bank #(.WIDTH(4), .MODE(2), .HOLD_CYCLES(3), .INIT(4'b0000)) u2 (
      .Clk(Clk), .ResetN(ResetN), .Enable(Enable), .Set(Set), .Reset(Reset),
      .Q(q[2]), .NotQ(nq[2]), .Changed(ch[2]), .Busy(bz[2]));
   sr_flop_bank #(.WIDTH(4), .MODE(3), .HOLD_CYCLES(0), .INIT(4'b0000)) u3 (
      .Clk(Clk), .ResetN(ResetN), .Enable(Enable), .Set(Set), .Reset(Reset),
      .Q(q[3]), .NotQ(nq[3]), .Changed(ch[3]), .Busy(bz[3]));
   sr_flop_bank #(.WIDTH(4), .MODE(0), .HOLD_CYCLES(5), .INIT(4'b0101)) u4 (
      .Clk(Clk), .ResetN(ResetN), .Enable(Enable), .Set(Set), .Reset(Reset),
      .Q(q[4]), .NotQ(nq[4]), .Changed(ch[4]), .Busy(bz[4]));
   sr_flop_bank #(.WIDTH(4), .MODE(2), .HOLD_CYCLES(0), .INIT(4'b0000)) u5 (
      .Clk(Clk), .ResetN(ResetN), .Enable(Enable), .Set(Set), .Reset(Reset),
      .Q(q[5]), .NotQ(nq[5]), .Changed(ch[5]), .Busy(bz[5]));

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset;
      ResetN = 1'b0;
      Enable = 1'b1;
      Set    = 4'b0000;
      Reset  = 4'b0000;
      tick();
      tick();
      ResetN = 1'b1;
   endtask

   task automatic test_reset;
      ResetN = 1'b0;
      Enable = 1'b1;
      Set    = 4'b0000;
      Reset  = 4'b0000;
      tick();
      tick();
      checks++; if (q[0] !== 4'b0101) begin errors++; $display("FAIL reset_q got=%b exp=0101", q[0]); end
      checks++; if (nq[0] !== 4'b1010) begin errors++; $display("FAIL reset_notq got=%b exp=1010", nq[0]); end
      checks++; if (ch[0] !== 4'b0000) begin errors++; $display("FAIL reset_changed got=%b exp=0000", ch[0]); end
      checks++; if (bz[2] !== 4'b0000) begin errors++; $display("FAIL reset_busy got=%b exp=0000", bz[2]); end
      ResetN = 1'b1;
      tick();
      checks++; if (q[0] !== 4'b0101) begin errors++; $display("FAIL reset_release_q got=%b exp=0101", q[0]); end
      checks++; if (ch[0] !== 4'b0000) begin errors++; $display("FAIL reset_release_changed got=%b exp=0000", ch[0]); end
   endtask

   task automatic test_set_reset;
      do_reset();
      Set   = 4'b1000;
      Reset = 4'b0001;
      tick();
      checks++; if (q[0] !== 4'b1100) begin errors++; $display("FAIL sr_q0 got=%b exp=1100", q[0]); end
      checks++; if (ch[0] !== 4'b1001) begin errors++; $display("FAIL sr_changed0 got=%b exp=1001", ch[0]); end
      checks++; if (q[1] !== 4'b1000) begin errors++; $display("FAIL sr_q1 got=%b exp=1000", q[1]); end
      Set   = 4'b0000;
      Reset = 4'b0000;
      tick();
      checks++; if (ch[0] !== 4'b0000) begin errors++; $display("FAIL sr_pulse_end got=%b exp=0000", ch[0]); end
      Set = 4'b1000;
      tick();
      checks++; if (q[0] !== 4'b1100) begin errors++; $display("FAIL sr_redundant_q got=%b exp=1100", q[0]); end
      checks++; if (ch[0] !== 4'b0000) begin errors++; $display("FAIL sr_redundant_changed got=%b exp=0000", ch[0]); end
      Set = 4'b0000;
   endtask

   task automatic test_conflict;
      do_reset();
      Set   = 4'b0010;
      Reset = 4'b0010;
      tick();
      checks++; if (q[0] !== 4'b0111) begin errors++; $display("FAIL conflict_mode0_q got=%b exp=0111", q[0]); end
      checks++; if (ch[0] !== 4'b0010) begin errors++; $display("FAIL conflict_mode0_changed got=%b exp=0010", ch[0]); end
      checks++; if (q[1] !== 4'b0000) begin errors++; $display("FAIL conflict_mode1_q got=%b exp=0000", q[1]); end
      checks++; if (ch[1] !== 4'b0000) begin errors++; $display("FAIL conflict_mode1_changed got=%b exp=0000", ch[1]); end
      checks++; if (q[3] !== 4'b0000) begin errors++; $display("FAIL conflict_mode3_q got=%b exp=0000", q[3]); end
      checks++; if (ch[3] !== 4'b0000) begin errors++; $display("FAIL conflict_mode3_changed got=%b exp=0000", ch[3]); end
      Set   = 4'b0000;
      Reset = 4'b0000;
      tick();
      checks++; if (ch[0] !== 4'b0000) begin errors++; $display("FAIL conflict_pulse_end got=%b exp=0000", ch[0]); end
   endtask

   task automatic test_toggle_lockout;
      logic exp_q, exp_b, exp_c;
      do_reset();
      Set   = 4'b0001;
      Reset = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_q = EDGE ? 1'b1 : (k <= 4);
         exp_b = EDGE ? (k <= 3) : (k != 4 && k != 8);
         exp_c = EDGE ? (k == 1) : (k == 1 || k == 5);
         checks++; if (q[2][0] !== exp_q) begin errors++; $display("FAIL toggle_q edge=%0d got=%b exp=%b", k, q[2][0], exp_q); end
         checks++; if (bz[2][0] !== exp_b) begin errors++; $display("FAIL toggle_busy edge=%0d got=%b exp=%b", k, bz[2][0], exp_b); end
         checks++; if (ch[2][0] !== exp_c) begin errors++; $display("FAIL toggle_changed edge=%0d got=%b exp=%b", k, ch[2][0], exp_c); end
      end
      Set   = 4'b0000;
      Reset = 4'b0000;
   endtask

   task automatic test_edge_toggle;
      logic exp_q, exp_c;
      do_reset();
      Set   = 4'b0010;
      Reset = 4'b0010;
      for (int k = 1; k <= 5; k++) begin
         tick();
         exp_q = EDGE ? 1'b1 : (k % 2 == 1);
         exp_c = EDGE ? (k == 1) : 1'b1;
         checks++; if (q[5][1] !== exp_q) begin errors++; $display("FAIL held_toggle_q edge=%0d got=%b exp=%b", k, q[5][1], exp_q); end
         checks++; if (ch[5][1] !== exp_c) begin errors++; $display("FAIL held_toggle_changed edge=%0d got=%b exp=%b", k, ch[5][1], exp_c); end
      end
      Set   = 4'b0000;
      Reset = 4'b0000;
   endtask

   task automatic test_enable;
      logic [3:0] exp_v;
      do_reset();
      Enable = 1'b0;
      Set    = 4'b1111;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (q[1] !== 4'b0000) begin errors++; $display("FAIL enable_off_q cycle=%0d got=%b exp=0000", k, q[1]); end
         checks++; if (ch[1] !== 4'b0000) begin errors++; $display("FAIL enable_off_changed cycle=%0d got=%b exp=0000", k, ch[1]); end
      end
      Enable = 1'b1;
      tick();
      exp_v = EDGE ? 4'b0000 : 4'b1111;
      checks++; if (q[1] !== exp_v) begin errors++; $display("FAIL enable_on_q got=%b exp=%b", q[1], exp_v); end
      checks++; if (ch[1] !== exp_v) begin errors++; $display("FAIL enable_on_changed got=%b exp=%b", ch[1], exp_v); end
      checks++; if (bz[2] !== exp_v) begin errors++; $display("FAIL enable_on_busy got=%b exp=%b", bz[2], exp_v); end
      // Lockout keeps counting down while requests are disabled.
      Enable = 1'b0;
      Set    = 4'b0000;
      for (int k = 1; k <= 3; k++) begin
         tick();
         exp_v = (EDGE || k == 3) ? 4'b0000 : 4'b1111;
         checks++; if (bz[2] !== exp_v) begin errors++; $display("FAIL enable_off_busy cycle=%0d got=%b exp=%b", k, bz[2], exp_v); end
      end
      checks++; if (ch[1] !== 4'b0000) begin errors++; $display("FAIL enable_pulse_end got=%b exp=0000", ch[1]); end
      Enable = 1'b1;
   endtask

   task automatic test_reset_busy;
      do_reset();
      Set = 4'b0010;
      tick();
      checks++; if (bz[4] !== 4'b0010) begin errors++; $display("FAIL rb_busy_start got=%b exp=0010", bz[4]); end
      Set = 4'b0000;
      tick();
      ResetN = 1'b0;
      tick();
      checks++; if (bz[4] !== 4'b0000) begin errors++; $display("FAIL rb_busy_abort got=%b exp=0000", bz[4]); end
      checks++; if (q[4] !== 4'b0101) begin errors++; $display("FAIL rb_q_init got=%b exp=0101", q[4]); end
      checks++; if (ch[4] !== 4'b0000) begin errors++; $display("FAIL rb_changed_clear got=%b exp=0000", ch[4]); end
      ResetN = 1'b1;
      Set    = 4'b0010;
      tick();
      checks++; if (q[4] !== 4'b0111) begin errors++; $display("FAIL rb_set_after_release got=%b exp=0111", q[4]); end
      checks++; if (ch[4] !== 4'b0010) begin errors++; $display("FAIL rb_changed_after_release got=%b exp=0010", ch[4]); end
      Set = 4'b0000;
   endtask

   initial begin
      ResetN = 1'b0;
      Enable = 1'b1;
      Set    = 4'b0000;
      Reset  = 4'b0000;
      test_reset();
      test_set_reset();
      test_conflict();
      test_toggle_lockout();
      test_edge_toggle();
      test_enable();
      test_reset_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
